// File: rtl/au_incdec_arbiter.sv
// N up/down counters sharing one incrementer-decrementer behind a round-robin arbiter.
// Define AU_INCDEC_ARBITER_SAT_EN for saturating counters and the rsp_sat output.

module AU_incdec #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] y_o,
  output logic             co_o
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;

  // bit k toggles when every lower bit propagates (all ones for inc, all zeros for dec)
  function automatic logic [WIDTH-1:0] pfx(input logic [WIDTH-1:0] pi);
    logic [WIDTH-1:0] t;
    t = pi;
    if (ARCH == 0) begin
      for (int k = 1; k < WIDTH; k++)
        t[k] = t[k] & t[k-1];
    end else if (ARCH == 1) begin
      for (int d = 1; d < WIDTH; d = d * 2)
        for (int k = WIDTH - 1; k >= d; k--)
          t[k] = t[k] & t[k-d];
    end else begin
      for (int l = 0; (1 << l) < WIDTH; l++)
        for (int k = 0; k < WIDTH; k++)
          if (((k >> l) & 1) == 1)
            t[k] = t[k] & t[((k >> (l + 1)) << (l + 1)) + (1 << l) - 1];
    end
    return t;
  endfunction

  // propagate terms, prefix-AND, then toggle
  always_comb begin
    p    = dec_i ? ~a_i : a_i;
    g    = pfx(p);
    y_o  = a_i;
    y_o[0] = ~a_i[0];
    for (int k = 1; k < WIDTH; k++)
      y_o[k] = a_i[k] ^ g[k-1];
    co_o = g[WIDTH-1];
  end

endmodule

module au_incdec_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int ARCH  = 0,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_dec,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
`ifdef AU_INCDEC_ARBITER_SAT_EN
  output logic                  rsp_sat,
`endif
  output logic [NREQ*WIDTH-1:0] cnt
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           dec;
  } ex_t;

  logic [NREQ*WIDTH-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic                  ex_vld_q, ex_vld_d;
  ex_t                   ex_q, ex_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]        rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic                  sat_q, sat_d;

  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gidx;
  logic                  gdec;
  logic                  found;
  logic [WIDTH-1:0]      opnd;
  logic [WIDTH-1:0]      au_y;
  logic                  au_co;
  logic [WIDTH-1:0]      result;
  logic                  sat;

  // round-robin search starting at rr_q
  always_comb begin : arb
    int idx;
    idx   = 0;
    gnt   = '0;
    gidx  = '0;
    gdec  = 1'b0;
    found = 1'b0;
    if (!rst && !clr) begin
      for (int j = 0; j < NREQ; j++) begin
        idx = (int'(rr_q) + j) % NREQ;
        if (!found && req_valid[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gidx     = IDW'(idx);
          gdec     = req_dec[idx];
        end
      end
    end
  end

  // operand fetch for the op in execute
  always_comb begin
    opnd = cnt_q[int'(ex_q.id)*WIDTH +: WIDTH];
  end

  AU_incdec #(
    .WIDTH(WIDTH),
    .ARCH (ARCH)
  ) u_au (
    .a_i  (opnd),
    .dec_i(ex_q.dec),
    .y_o  (au_y),
    .co_o (au_co)
  );

  // carry-out means inc at all-ones or dec at zero
`ifdef AU_INCDEC_ARBITER_SAT_EN
  always_comb begin
    sat    = au_co;
    result = au_co ? opnd : au_y;
  end
`else
  always_comb begin
    sat    = 1'b0;
    result = au_y;
  end
`endif

  // next state: clr wipes counters and the in-flight op
  always_comb begin
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    ex_vld_d    = 1'b0;
    ex_d        = ex_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    sat_d       = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else begin
      if (found) begin
        ex_vld_d = 1'b1;
        ex_d.id  = gidx;
        ex_d.dec = gdec;
        if (int'(gidx) == NREQ - 1)
          rr_d = '0;
        else
          rr_d = gidx + 1'b1;
      end
      if (ex_vld_q) begin
        cnt_d[int'(ex_q.id)*WIDTH +: WIDTH] = result;
        rsp_valid_d = 1'b1;
        rsp_id_d    = ex_q.id;
        rsp_data_d  = result;
        sat_d       = sat;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rr_q        <= '0;
      ex_vld_q    <= 1'b0;
      ex_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      ex_vld_q    <= ex_vld_d;
      ex_q        <= ex_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      sat_q       <= sat_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign cnt       = cnt_q;
`ifdef AU_INCDEC_ARBITER_SAT_EN
  assign rsp_sat   = sat_q;
`else
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_au_incdec_arbiter.sv
// Scoreboard bench for au_incdec_arbiter: an 8x4 instance with random traffic
// and a 1x1 instance; expectations come from a counter-array model.

module tb_au_incdec_arbiter;

  logic       clk;
  logic       rst, clr;
  logic [3:0] req_valid, req_dec, req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;
  logic [31:0] cnt;
  logic       rsp_sat;

  logic       rst1, clr1, v1, d1, rdy1, rv1, rid1, rdat1, cnt1;
  logic       sat1;

  typedef struct {
    int id;
    int data;
    bit sat;
    int acc;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  int   mcnt[4];
  int   rr;
  bit   infl;
  int   m1;
  bit   infl1;
  int   cyc;
  int   errors;
  int   checks;

  au_incdec_arbiter #(.WIDTH(8), .NREQ(4), .ARCH(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .req_valid(req_valid),
    .req_dec  (req_dec),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
`ifdef AU_INCDEC_ARBITER_SAT_EN
    .rsp_sat  (rsp_sat),
`endif
    .cnt      (cnt)
  );

  au_incdec_arbiter #(.WIDTH(1), .NREQ(1), .ARCH(2)) dut1 (
    .clk      (clk),
    .rst      (rst1),
    .clr      (clr1),
    .req_valid(v1),
    .req_dec  (d1),
    .req_ready(rdy1),
    .rsp_valid(rv1),
    .rsp_id   (rid1),
    .rsp_data (rdat1),
`ifdef AU_INCDEC_ARBITER_SAT_EN
    .rsp_sat  (sat1),
`endif
    .cnt      (cnt1)
  );

`ifndef AU_INCDEC_ARBITER_SAT_EN
  assign rsp_sat = 1'b0;
  assign sat1    = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // counter arithmetic from the rules: +/-1 mod 2^w, or clamp when saturating
  task automatic model_op(input int val, input bit dec, input int w,
                          output int nv, output bit s);
    int mx;
    mx = (1 << w) - 1;
    s  = 1'b0;
`ifdef AU_INCDEC_ARBITER_SAT_EN
    if ((!dec && val == mx) || (dec && val == 0)) begin
      s  = 1'b1;
      nv = val;
      return;
    end
`endif
    nv = dec ? (val + mx) % (mx + 1) : (val + 1) % (mx + 1);
  endtask

  // main monitor: pops one expectation per response pulse
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_latency", 32'(cyc), 32'(e.acc + 2));
`ifdef AU_INCDEC_ARBITER_SAT_EN
        chk("rsp_sat", 32'(rsp_sat), 32'(e.sat));
`endif
      end
    end else if (q.size() > 0 && cyc >= q[0].acc + 2) begin
      e = q.pop_front();
      chk("missing_rsp", 32'(rsp_valid), 32'd1);
    end
  end

  // width-1 monitor
  always @(negedge clk) begin
    exp_t e;
    if (rv1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("w1_spurious_rsp", 32'(rv1), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("w1_rsp_data", 32'(rdat1), 32'(e.data));
        chk("w1_rsp_id", 32'(rid1), 32'd0);
        chk("w1_latency", 32'(cyc), 32'(e.acc + 2));
`ifdef AU_INCDEC_ARBITER_SAT_EN
        chk("w1_rsp_sat", 32'(sat1), 32'(e.sat));
`endif
      end
    end else if (q1.size() > 0 && cyc >= q1[0].acc + 2) begin
      e = q1.pop_front();
      chk("w1_missing_rsp", 32'(rv1), 32'd1);
    end
  end

  // one cycle of main-DUT stimulus; called at posedge+1
  task automatic cycle(input logic [3:0] v, input logic [3:0] d,
                       input logic c, input logic r);
    int   g;
    int   nv;
    bit   s;
    logic [3:0] eg;
    exp_t e;
    req_valid = v;
    req_dec   = d;
    clr       = c;
    rst       = r;
    #1;
    g = -1;
    if (!r && !c)
      for (int j = 0; j < 4; j++)
        if (g < 0 && v[(rr + j) % 4]) g = (rr + j) % 4;
    eg = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(eg));
    if (r || c) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      if (r) rr = 0;
      if (infl) void'(q.pop_back());
      infl = 1'b0;
    end else if (g >= 0) begin
      model_op(mcnt[g], d[g], 8, nv, s);
      mcnt[g] = nv;
      e.id = g; e.data = nv; e.sat = s; e.acc = cyc;
      q.push_back(e);
      rr   = (g + 1) % 4;
      infl = 1'b1;
    end else begin
      infl = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_check();
    cycle(4'd0, 4'd0, 1'b0, 1'b0);
    cycle(4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("cnt%0d", i), 32'(cnt[i*8 +: 8]), 32'(mcnt[i]));
  endtask

  task automatic cycle1(input logic v, input logic r);
    int   nv;
    bit   s;
    exp_t e;
    v1   = v;
    d1   = 1'b0;
    rst1 = r;
    #1;
    chk("w1_ready", 32'(rdy1), 32'(v & ~r));
    if (r) begin
      m1 = 0;
      if (infl1) void'(q1.pop_back());
      infl1 = 1'b0;
    end else if (v) begin
      model_op(m1, 1'b0, 1, nv, s);
      m1 = nv;
      e.id = 0; e.data = nv; e.sat = s; e.acc = cyc;
      q1.push_back(e);
      infl1 = 1'b1;
    end else begin
      infl1 = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rv, rd;
    errors = 0; checks = 0; cyc = 0;
    rr = 0; infl = 0; m1 = 0; infl1 = 0;
    foreach (mcnt[i]) mcnt[i] = 0;
    rst = 1'b1; clr = 1'b0; req_valid = '0; req_dec = '0;
    rst1 = 1'b1; clr1 = 1'b0; v1 = 1'b0; d1 = 1'b0;
    @(posedge clk);
    #1;
    cycle(4'd0, 4'd0, 1'b0, 1'b1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_cnt", cnt, 32'd0);

    // single requester, three increments
    for (int i = 0; i < 3; i++) cycle(4'b0001, 4'd0, 1'b0, 1'b0);
    cnt_check();

    // all requesting from rr_ptr=0
    cycle(4'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'b1111, 4'd0, 1'b0, 1'b0);
    cnt_check();

    // decrement at zero
    cycle(4'd0, 4'd0, 1'b0, 1'b1);
    cycle(4'b0100, 4'b0100, 1'b0, 1'b0);
    cnt_check();

    // back-to-back inc/dec on one counter from 0x10
    cycle(4'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(4'b0010, 4'd0, 1'b0, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
    cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
    cnt_check();

    // clr with an op in flight, then confirm pointer held
    cycle(4'b0001, 4'd0, 1'b0, 1'b0);
    cycle(4'b1111, 4'd0, 1'b0, 1'b0);
    cycle(4'b1111, 4'd0, 1'b1, 1'b0);
    chk("clr_cnt", cnt, 32'd0);
    cycle(4'b1111, 4'd0, 1'b0, 1'b0);
    cnt_check();

    // reset with an op in flight
    cycle(4'b1000, 4'b0000, 1'b0, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b0, 1'b1);
    cnt_check();

    // random traffic with occasional clr/rst
    for (int i = 0; i < 400; i++) begin
      rv = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      cycle(rv, rd, ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end
    cnt_check();

    // width-1 single-requester instance
    cycle1(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle1(1'b1, 1'b0);
    cycle1(1'b0, 1'b0);
    cycle1(1'b0, 1'b0);
    chk("w1_cnt", 32'(cnt1), 32'(m1));
    cycle1(1'b1, 1'b0);
    cycle1(1'b0, 1'b1);
    cycle1(1'b0, 1'b0);
    cycle1(1'b0, 1'b0);
    chk("w1_rst_cnt", 32'(cnt1), 32'd0);

    cycle(4'd0, 4'd0, 1'b0, 1'b0);
    cycle(4'd0, 4'd0, 1'b0, 1'b0);
    chk("drain_main", 32'(q.size()), 32'd0);
    chk("drain_w1", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/au_incdec_arbiter.md
Name: au_incdec_arbiter

Overview:
- Bank of NREQ WIDTH-bit up/down counters, one per requester, sharing a single AU_incdec instance.
- Round-robin arbiter admits one inc/dec request per cycle. A one-stage execute register feeds the shared incdec and writes the result back.
- Sits between event sources (per-channel credit/occupancy trackers) and the shared arithmetic unit, so N counters cost one incrementer-decrementer.

Parameters:
- WIDTH, 8, counter word length (>= 1), passed to AU_incdec.
- NREQ, 4, number of requesters/counters (>= 1).
- ARCH, 0, prefix architecture (0 to 2), passed to AU_incdec.
- Local IDW = max(1, ceil(log2(NREQ))).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active high.
- clr  input  1  synchronous clear of all counters.
- req_valid  input  NREQ  bit i: requester i has an op pending.
- req_dec  input  NREQ  bit i: 0 = increment, 1 = decrement.
- req_ready  output  NREQ  one-hot grant; op i accepted when req_valid[i] & req_ready[i].
- rsp_valid  output  1  one-cycle pulse: an op completed.
- rsp_id  output  IDW  counter index of the completed op.
- rsp_data  output  WIDTH  new counter value of the completed op.
- cnt  output  NREQ*WIDTH  all counters; counter i in bits [i*WIDTH +: WIDTH].

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active high.
- Reset values: all counters 0, rr_ptr 0, execute stage empty, rsp_valid 0, rsp_id 0, rsp_data 0. req_ready is combinational and therefore 0 while rst = 1.
- Arbitration (combinational):
  - Priority order is rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[i] = 1 only for the first i in that order with req_valid[i] = 1. All bits are 0 when no request is valid, or when rst or clr is 1.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: on an accept of index g, rr_ptr <= (g+1) mod NREQ at that edge; otherwise rr_ptr holds. NREQ = 1 means always grant index 0.
- Execute stage:
  - The accepted op {id, dec} is registered at edge t.
  - In the following cycle the operand is cnt[id] and the result comes from the single shared AU_incdec.
  - At edge t+1: cnt[id] <= result, rsp_valid <= 1, rsp_id <= id, rsp_data <= result.
  - Latency is accept-to-counter-update of 1 cycle, with rsp_valid high the cycle after edge t+1. Throughput is 1 op/cycle.
- Back-to-back ops on the same counter: the write at edge t+1 is visible to the op executing in cycle t+1 without forwarding, so there is no hazard and every op counts exactly once.
- Arithmetic: modulo 2^WIDTH by default (0xFF+1 = 0x00, 0x00-1 = 0xFF for WIDTH=8). WIDTH = 1 toggles the bit.
- rsp_valid is 0 in any cycle following an edge with no executed op.
- clr:
  - At an edge with clr = 1, all counters become 0.
  - The op in execute is dropped: no writeback and rsp_valid <= 0.
  - No new op is accepted. rr_ptr holds.
- rst mid-operation: identical to reset. The in-flight op is discarded and produces no response.
- Counters change only via execute writeback, clr or rst.

Optional Feature:
- Macro AU_INCDEC_ARBITER_SAT_EN.
- When defined:
  - Counters saturate: an increment at all-ones and a decrement at zero leave the value unchanged.
  - An extra output port rsp_sat (1 bit) pulses alongside rsp_valid when the op saturated. It resets to 0.
  - rsp_data shows the held value.
- When not defined: wrap-around arithmetic as above, and the rsp_sat port does not exist.

Test Plan:
- Reset, then req_valid=0001 and req_dec=0000 held for 3 cycles (WIDTH=8, NREQ=4) -> req_ready=0001 each cycle; rsp_data 01, 02, 03 with rsp_id=0; cnt[0]=0x03; other counters 0.
- req_valid=1111 held, rr_ptr=0 -> grants cycle 0001, 0010, 0100, 1000, 0001; each counter increments once per 4 cycles; rsp_id sequence 0, 1, 2, 3, 0.
- cnt[2]=0x00, single decrement on requester 2 -> rsp_data=0xFF without the macro; with AU_INCDEC_ARBITER_SAT_EN, rsp_data=0x00 and rsp_sat=1.
- cnt[1]=0x10: inc, dec, dec, inc on requester 1 in consecutive cycles -> rsp_data 0x11, 0x10, 0x0F, 0x10; final cnt[1]=0x10, with no lost update.
- Op accepted at edge t, then clr=1 at edge t+1 -> no rsp_valid, all cnt=0, req_ready=0 during the clr cycle, rr_ptr unchanged.
- WIDTH=1, NREQ=1: four increments -> rsp_data 1, 0, 1, 0; rst asserted with an op in flight -> rsp_valid stays 0, cnt=0.
